// File: rtl/synth_param_writer_if.sv
// Parameter-write bus for the synth engine: request stream plus the strobed register-write port.
// The master is the writer. The slave is the front end and the parameter registers.
interface synth_param_writer_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_bank;
  logic [6:0] in_adr;
  logic [7:0] in_data;
  logic [7:0] data;
  logic [6:0] adr;
  logic       write;
  logic       osc_sel;
  logic       com_sel;
  logic       m1_sel;
  logic       m2_sel;

  modport master (
    input  in_valid, in_bank, in_adr, in_data,
    output in_ready, data, adr, write, osc_sel, com_sel, m1_sel, m2_sel
  );

  modport slave (
    output in_valid, in_bank, in_adr, in_data,
    input  in_ready, data, adr, write, osc_sel, com_sel, m1_sel, m2_sel
  );
endinterface

// File: rtl/synth_param_writer.sv
// Buffers parameter requests in a FIFO and replays each one as a setup/strobe/hold write cycle.
// Optional macro PARAM_WR_DROP_EN: drop requests that arrive while full and pulse overflow.
module synth_param_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 2
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  synth_param_writer_if.master bus,
  output logic                 busy,
  output logic                 overflow
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC)
                         ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                         : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef struct packed {
    logic [1:0] bank;
    logic [6:0] adr;
    logic [7:0] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  req_t           mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr, vis_ptr, rd_ptr;
  logic           full, avail, push, pop;
  req_t           head;

  state_t         state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]     data_q;
  logic [6:0]     adr_q;
  logic           write_q;
  logic [3:0]     sel_q;

  // vis_ptr trails wr_ptr by one cycle so a new entry reaches the FSM one cycle after acceptance.
  assign full  = (wr_ptr - rd_ptr) == (PTR_W + 1)'(FIFO_DEPTH);
  assign avail = (vis_ptr != rd_ptr);
  assign head  = mem[rd_ptr[PTR_W-1:0]];
  assign push  = bus.in_valid && !full && !iRST;
  assign pop   = (state == IDLE) && avail && !iRST;
  assign busy  = (state != IDLE) || (wr_ptr != rd_ptr);

`ifdef PARAM_WR_DROP_EN
  assign bus.in_ready = !iRST;
  assign overflow     = !iRST && bus.in_valid && full;
`else
  assign bus.in_ready = !iRST && !full;
  assign overflow     = 1'b0;
`endif

  // NOTE: storage has no reset; pointers alone define which entries are valid.
  always_ff @(posedge iCLK) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= '{bus.in_bank, bus.in_adr, bus.in_data};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wr_ptr  <= '0;
      vis_ptr <= '0;
      rd_ptr  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
      vis_ptr <= wr_ptr;
      if (pop) rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= IDLE;
      cnt     <= '0;
      data_q  <= '0;
      adr_q   <= '0;
      write_q <= 1'b1;
      sel_q   <= '0;
    end else begin
      case (state)
        IDLE: if (avail) begin
          data_q <= head.data;
          adr_q  <= head.adr;
          sel_q  <= 4'b0001 << head.bank;
          cnt    <= CNT_W'(SETUP_CYC - 1);
          state  <= SETUP;
        end
        SETUP: if (cnt == '0) begin
          write_q <= 1'b0;
          cnt     <= CNT_W'(STROBE_CYC - 1);
          state   <= STROBE;
        end else cnt <= cnt - CNT_W'(1);
        STROBE: if (cnt == '0) begin
          write_q <= 1'b1;
          cnt     <= CNT_W'(HOLD_CYC - 1);
          state   <= HOLD;
        end else cnt <= cnt - CNT_W'(1);
        HOLD: if (cnt == '0) begin
          sel_q <= '0;
          state <= IDLE;
        end else cnt <= cnt - CNT_W'(1);
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data    = data_q;
  assign bus.adr     = adr_q;
  assign bus.write   = write_q;
  assign bus.osc_sel = sel_q[0];
  assign bus.com_sel = sel_q[1];
  assign bus.m1_sel  = sel_q[2];
  assign bus.m2_sel  = sel_q[3];

endmodule
